// File: rtl/riscv_lsu_pkg.sv
// Shared access-size encodings and alignment helper for the RISC-V load/store unit.
package riscv_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] off);
        logic f;
        f = 1'b0;
        case (size)
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = off[0];
            SIZE_WORD: f = (off != 2'b00);
            default:   f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane formatting: store enables/replication and load extraction/extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be    = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        shifted = ld_raw >> {ld_off, 3'b000};
        ld_data = ld_raw;
        case (ld_size)
            SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: ld_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default:   ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: IDLE accepts, BUS waits for ack or timeout,
// RESP emits a one-cycle completion pulse.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_we_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, next;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, err_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q;

    logic        accept, fault, in_bus, expired;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    riscv_lsu_align u_align (
        .st_off      (req_addr_i[1:0]),
        .st_size     (req_size_i),
        .st_data     (req_wdata_i),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_off      (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_raw      (mem_rdata_i),
        .ld_data     (ld_data)
    );

    assign fault   = is_fault(req_size_i, req_addr_i[1:0]);
    assign expired = (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next        = state;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        in_bus      = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_o = !reset_i;
                accept      = req_valid_i && !reset_i;
                if (accept) next = fault ? RESP : BUS;
            end
            BUS: begin
                in_bus = 1'b1;
                if (mem_ack_i || expired) next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                next        = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= st_wdata;
            size_q  <= req_size_i;
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            be_q    <= st_be;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= fault;
        end else if (in_bus) begin
            // ack wins over an expiring counter
            if (mem_ack_i) begin
                rdata_q <= we_q ? 32'h0 : ld_data;
                err_q   <= 1'b0;
            end else if (expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign mem_rd_o    = in_bus && !we_q;
    assign mem_wr_o    = in_bus && we_q;
    assign mem_addr_o  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be_o    = in_bus ? be_q : 4'h0;
    assign mem_wdata_o = in_bus ? wdata_q : 32'h0;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
    assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (TIMEOUT_CYCLES=4).
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_we_i = 1'b0;
    logic        req_unsigned_i = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int vecs = 0;
    int errs = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_size_i(req_size_i), .req_we_i(req_we_i),
        .req_unsigned_i(req_unsigned_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic issue(input logic [31:0] a, input logic [1:0] s,
                         input logic we, input logic u, input logic [31:0] wd);
        @(negedge clk_i);
        vecs++;
        if (req_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL ready_before_issue: got %b expected 1", req_ready_o);
        end
        req_valid_i = 1'b1; req_addr_i = a; req_size_i = s;
        req_we_i = we; req_unsigned_i = u; req_wdata_i = wd;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({req_ready_o, mem_rd_o, mem_wr_o, rsp_valid_o, rsp_err_o} !== 5'b0 ||
            mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || rsp_rdata_o !== 32'h0) begin
            errs++;
            $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b v=%b be=%h expected all 0",
                     req_ready_o, mem_rd_o, mem_wr_o, rsp_valid_o, mem_be_o);
        end
        @(negedge clk_i); @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        vecs++;
        if (req_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready_o);
        end
    endtask

    task automatic test_signed_byte;
        issue(32'h103, SIZE_BYTE, 1'b0, 1'b0, 32'h0);
        vecs++;
        if (mem_rd_o !== 1'b1 || mem_wr_o !== 1'b0 || mem_addr_o !== 32'h100 ||
            mem_be_o !== 4'b1000 || rsp_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL sbyte_bus: got rd=%b wr=%b addr=%h be=%b v=%b expected 1 0 100 1000 0",
                     mem_rd_o, mem_wr_o, mem_addr_o, mem_be_o, rsp_valid_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h80FF_FF7F;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        vecs++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FF80 ||
            rsp_err_o !== 1'b0 || mem_rd_o !== 1'b0) begin
            errs++;
            $display("FAIL sbyte_rsp: got v=%b d=%h e=%b rd=%b expected 1 ffffff80 0 0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_rd_o);
        end
        @(negedge clk_i);
        vecs++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || req_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL sbyte_after: got v=%b d=%h rdy=%b expected 0 0 1",
                     rsp_valid_o, rsp_rdata_o, req_ready_o);
        end
    endtask

    task automatic test_half_store;
        issue(32'h206, SIZE_HALF, 1'b1, 1'b0, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (mem_wr_o !== 1'b1 || mem_rd_o !== 1'b0 || mem_addr_o !== 32'h204 ||
                mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hBEEF_BEEF ||
                rsp_valid_o !== 1'b0) begin
                errs++;
                $display("FAIL hstore_bus%0d: got wr=%b addr=%h be=%b wd=%h v=%b expected 1 204 1100 beefbeef 0",
                         i, mem_wr_o, mem_addr_o, mem_be_o, mem_wdata_o, rsp_valid_o);
            end
            if (i == 2) begin
                mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
            end
            @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        vecs++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 ||
            mem_wr_o !== 1'b0) begin
            errs++;
            $display("FAIL hstore_rsp: got v=%b d=%h e=%b wr=%b expected 1 0 0 0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_wr_o);
        end
        @(negedge clk_i);
        vecs++;
        if (rsp_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL hstore_single: got v=%b expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_byte_store;
        issue(32'h11, SIZE_BYTE, 1'b1, 1'b0, 32'h1234_5678);
        vecs++;
        if (mem_wr_o !== 1'b1 || mem_be_o !== 4'b0010 || mem_wdata_o !== 32'h7878_7878 ||
            mem_addr_o !== 32'h10) begin
            errs++;
            $display("FAIL bstore_bus: got wr=%b be=%b wd=%h addr=%h expected 1 0010 78787878 10",
                     mem_wr_o, mem_be_o, mem_wdata_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_faults;
        logic [31:0] fa [2];
        logic [1:0]  fs [2];
        fa[0] = 32'h302; fs[0] = SIZE_WORD;
        fa[1] = 32'h300; fs[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            issue(fa[i], fs[i], 1'b0, 1'b0, 32'h0);
            vecs++;
            if (mem_rd_o !== 1'b0 || mem_wr_o !== 1'b0 || rsp_valid_o !== 1'b1 ||
                rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
                errs++;
                $display("FAIL fault%0d: got rd=%b wr=%b v=%b e=%b d=%h expected 0 0 1 1 0",
                         i, mem_rd_o, mem_wr_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
            end
            @(negedge clk_i);
            vecs++;
            if (rsp_valid_o !== 1'b0 || mem_rd_o !== 1'b0 || req_ready_o !== 1'b1) begin
                errs++;
                $display("FAIL fault%0d_after: got v=%b rd=%b rdy=%b expected 0 0 1",
                         i, rsp_valid_o, mem_rd_o, req_ready_o);
            end
        end
    endtask

    task automatic test_loads;
        logic [31:0] la [5];
        logic [1:0]  ls [5];
        logic        lu [5];
        logic [31:0] lr [5];
        logic [31:0] le [5];
        logic [3:0]  lb [5];
        la[0] = 32'h001; ls[0] = SIZE_BYTE; lu[0] = 1; lr[0] = 32'h0000_AB00; le[0] = 32'h0000_00AB; lb[0] = 4'b0010;
        la[1] = 32'h002; ls[1] = SIZE_HALF; lu[1] = 0; lr[1] = 32'h8001_0000; le[1] = 32'hFFFF_8001; lb[1] = 4'b1100;
        la[2] = 32'h000; ls[2] = SIZE_HALF; lu[2] = 1; lr[2] = 32'h0000_F00F; le[2] = 32'h0000_F00F; lb[2] = 4'b0011;
        la[3] = 32'h004; ls[3] = SIZE_WORD; lu[3] = 0; lr[3] = 32'hDEAD_BEEF; le[3] = 32'hDEAD_BEEF; lb[3] = 4'b1111;
        la[4] = 32'h002; ls[4] = SIZE_BYTE; lu[4] = 0; lr[4] = 32'h007F_0000; le[4] = 32'h0000_007F; lb[4] = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            issue(la[i], ls[i], 1'b0, lu[i], 32'h0);
            vecs++;
            if (mem_rd_o !== 1'b1 || mem_be_o !== lb[i]) begin
                errs++;
                $display("FAIL load%0d_be: got rd=%b be=%b expected 1 %b", i, mem_rd_o, mem_be_o, lb[i]);
            end
            mem_ack_i = 1'b1; mem_rdata_i = lr[i];
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            vecs++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== le[i] || rsp_err_o !== 1'b0) begin
                errs++;
                $display("FAIL load%0d_data: got v=%b d=%h e=%b expected 1 %h 0",
                         i, rsp_valid_o, rsp_rdata_o, rsp_err_o, le[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_timeout;
        issue(32'h500, SIZE_WORD, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (mem_rd_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
                errs++;
                $display("FAIL timeout_hold%0d: got rd=%b v=%b expected 1 0", i, mem_rd_o, rsp_valid_o);
            end
            @(negedge clk_i);
        end
        vecs++;
        if (mem_rd_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 ||
            rsp_rdata_o !== 32'h0) begin
            errs++;
            $display("FAIL timeout_rsp: got rd=%b v=%b e=%b d=%h expected 0 1 1 0",
                     mem_rd_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        @(negedge clk_i);
        vecs++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL timeout_ready: got rdy=%b v=%b expected 1 0", req_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_ack_priority;
        issue(32'h600, SIZE_WORD, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk_i);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        vecs++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1122_3344) begin
            errs++;
            $display("FAIL ack_priority: got v=%b e=%b d=%h expected 1 0 11223344",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_idle_ack;
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_AAAA;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        vecs++;
        if (rsp_valid_o !== 1'b0 || mem_rd_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL idle_ack: got v=%b rd=%b rdy=%b expected 0 0 1",
                     rsp_valid_o, mem_rd_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        issue(32'h402, SIZE_HALF, 1'b0, 1'b1, 32'h0);
        @(negedge clk_i);
        vecs++;
        if (mem_rd_o !== 1'b1) begin
            errs++;
            $display("FAIL midrst_bus: got rd=%b expected 1", mem_rd_o);
        end
        reset_i = 1'b1;
        #1;
        vecs++;
        if (mem_rd_o !== 1'b0 || mem_addr_o !== 32'h0 || req_ready_o !== 1'b0 ||
            rsp_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL midrst_async: got rd=%b addr=%h rdy=%b v=%b expected 0 0 0 0",
                     mem_rd_o, mem_addr_o, req_ready_o, rsp_valid_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) pulses++;
        end
        vecs++;
        if (pulses !== 0) begin
            errs++;
            $display("FAIL midrst_no_rsp: got %0d pulses expected 0", pulses);
        end
        issue(32'h402, SIZE_HALF, 1'b0, 1'b1, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        vecs++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_1234 || rsp_err_o !== 1'b0) begin
            errs++;
            $display("FAIL midrst_reload: got v=%b d=%h e=%b expected 1 00001234 0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_signed_byte();
        test_half_store();
        test_byte_store();
        test_faults();
        test_loads();
        test_timeout();
        test_ack_priority();
        test_idle_ack();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
